// File: rtl/ram8_ctrl_pkg.sv
// Shared types and constants for the ram8 round-robin access controller.
package ram8_ctrl_pkg;

  localparam int RAM_DW = 16;
  localparam int RAM_AW = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic client_id_t;

endpackage

// File: rtl/ram8_rr_arb2.sv
// Two-way round-robin arbiter: ptr names the client that wins a tie,
// and after each grant it moves to the client that lost (or did not ask).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~grant[1];
    end
  end

endmodule

// File: rtl/ram8_rr_ctrl.sv
// Round-robin controller serialising two clients' read/write commands onto
// the single ram8 port; each command runs IDLE -> ACCESS -> RESP.
module ram8_rr_ctrl
  import ram8_ctrl_pkg::*;
#(
  parameter int DW = RAM_DW,
  parameter int AW = RAM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_w,
  output logic          ram_r,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_t     state;
  logic [1:0] req_vec;
  logic [1:0] grant;
  logic       ptr;
  logic       advance;
  client_id_t win_id;
  client_id_t cmd_id;
  logic       cmd_we;

  assign req_vec = {req1, req0};
  assign advance = (state == IDLE) && (|req_vec);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_vec),
    .advance (advance),
    .grant   (grant),
    .ptr     (ptr)
  );

  // Grants are combinational so the client sees acceptance in its request cycle.
  assign gnt0   = (state == IDLE) && grant[0];
  assign gnt1   = (state == IDLE) && grant[1];
  assign win_id = (&req_vec) ? ptr : req_vec[1];

  // RAM strobes are registered on entry to ACCESS, so they are high only there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cmd_id  <= 1'b0;
      cmd_we  <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      ram_en  <= 1'b0;
      ram_w   <= 1'b0;
      ram_r   <= 1'b0;
      ram_add <= '0;
      ram_din <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (advance) begin
            cmd_id  <= win_id;
            cmd_we  <= win_id ? we1 : we0;
            ram_add <= win_id ? addr1 : addr0;
            if (win_id ? we1 : we0) begin
              ram_din <= win_id ? wdata1 : wdata0;
            end
            ram_en  <= 1'b1;
            ram_w   <= win_id ? we1 : we0;
            ram_r   <= win_id ? ~we1 : ~we0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en <= 1'b0;
          ram_w  <= 1'b0;
          ram_r  <= 1'b0;
          if (!cmd_we) begin
            rdata <= ram_dout;
          end
          done0 <= (cmd_id == 1'b0);
          done1 <= (cmd_id == 1'b1);
          state <= RESP;
        end
        RESP: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_en <= 1'b0;
          ram_w  <= 1'b0;
          ram_r  <= 1'b0;
          done0  <= 1'b0;
          done1  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_rr_ctrl.sv
// Scoreboard bench for ram8_rr_ctrl with a behavioural 8x16 RAM attached.
module tb_ram8_rr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [2:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] rdata;
  logic        ram_en, ram_w, ram_r;
  logic [2:0]  ram_add;
  logic [15:0] ram_din, ram_dout;

  logic [15:0] mem [8];
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    bit          id;
    bit          rd;
    logic [15:0] data;
  } exp_t;
  exp_t        q[$];
  string       chk_n[$];
  logic [31:0] chk_a[$];
  logic [31:0] chk_e[$];
  logic [15:0] last_read = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ram8_rr_ctrl #(.DW(16), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .ram_en(ram_en), .ram_w(ram_w), .ram_r(ram_r),
    .ram_add(ram_add), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM stand-in; a recognisable pattern is driven when not reading.
  always @(posedge clk) if (ram_en && ram_w) mem[ram_add] <= ram_din;
  assign ram_dout = (ram_en && ram_r) ? mem[ram_add] : 16'hDEAD;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_n.push_back(n);
    chk_a.push_back(a);
    chk_e.push_back(e);
  endtask

  // Monitor: sole owner of the counters; evaluates queued checks and done responses.
  always @(negedge clk) begin
    exp_t e;
    while (chk_n.size() != 0) begin
      string n;
      logic [31:0] a, x;
      n = chk_n.pop_front();
      a = chk_a.pop_front();
      x = chk_e.pop_front();
      vectors++;
      if (a !== x) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", n, a, x);
      end
    end
    if (!rst_n) begin
      last_read = '0;
    end else begin
      vectors++;
      if ((gnt0 && gnt1) || (done0 && done1) || ((gnt0 || gnt1) && (done0 || done1))) begin
        miscompares++;
        $display("FAIL exclusive: gnt=%b%b done=%b%b expected no overlap", gnt1, gnt0, done1, done0);
      end
      if (done0 || done1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: done=%b%b expected none", done1, done0);
        end else begin
          e = q.pop_front();
          if (done1 !== e.id) begin
            miscompares++;
            $display("FAIL done_id: got %0d expected %0d", done1, e.id);
          end else if (e.rd && rdata !== e.data) begin
            miscompares++;
            $display("FAIL read_data: got %h expected %h", rdata, e.data);
          end else if (!e.rd && rdata !== last_read) begin
            miscompares++;
            $display("FAIL rdata_hold: got %h expected %h", rdata, last_read);
          end
          if (e.rd) last_read = e.data;
        end
      end
    end
  end

  task automatic set_client(input bit id, input logic r, input logic w,
                            input logic [2:0] a, input logic [15:0] d);
    if (id) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else    begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  // Waits (bounded) for a grant to the selected clients; returns at the negedge of it.
  task automatic wait_gnt(input bit any, input bit id, output bit got);
    int unsigned n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (any ? (gnt0 || gnt1) : (id ? gnt1 : gnt0)) got = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    check("gnt_wait", {31'd0, got}, 32'd1);
  endtask

  // Issues one command starting just after a rising edge, returns at the next IDLE.
  task automatic cmd(input bit id, input bit we, input logic [2:0] a,
                     input logic [15:0] d, input logic [15:0] exp_rd);
    bit got;
    set_client(id, 1'b1, we, a, d);
    wait_gnt(1'b0, id, got);
    if (got) begin
      q.push_back('{id, !we, exp_rd});
      @(posedge clk); #1;
      set_client(id, 1'b0, !we, ~a, ~d);
      @(negedge clk);
      check("access_strobes", {29'd0, ram_en, ram_w, ram_r}, {29'd0, 1'b1, we, !we});
      check("access_add", {29'd0, ram_add}, {29'd0, a});
      if (we) check("access_din", {16'd0, ram_din}, {16'd0, d});
      @(posedge clk); @(posedge clk); #1;
    end
  endtask

  initial begin
    bit got;
    int unsigned last_cyc;
    int unsigned n;

    #12;
    check("reset_outputs", {23'd0, gnt0, gnt1, done0, done1, ram_en, ram_w, ram_r, ram_add}, 32'd0);
    check("reset_din_rdata", {ram_din, rdata}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    cmd(1'b0, 1'b1, 3'd3, 16'hA5A5, 16'h0000);
    cmd(1'b0, 1'b0, 3'd3, 16'h0000, 16'hA5A5);

    cmd(1'b1, 1'b1, 3'd7, 16'h1234, 16'h0000);
    cmd(1'b0, 1'b1, 3'd0, 16'hFFFF, 16'h0000);
    cmd(1'b0, 1'b1, 3'd5, 16'h0BEE, 16'h0000);
    cmd(1'b1, 1'b0, 3'd7, 16'h0000, 16'h1234);
    cmd(1'b0, 1'b0, 3'd0, 16'h0000, 16'hFFFF);
    cmd(1'b1, 1'b0, 3'd5, 16'h0000, 16'h0BEE);

    // Lone requester: held request must be granted every third cycle.
    set_client(1'b1, 1'b1, 1'b0, 3'd7, 16'h0000);
    last_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(1'b0, 1'b1, got);
      if (got) begin
        q.push_back('{1'b1, 1'b1, 16'h1234});
        if (i > 0) check("lone_gap", cyc - last_cyc, 32'd3);
        last_cyc = cyc;
        @(posedge clk); #1;
        if (i == 3) req1 = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset during ACCESS of a write granted to client 0 (pointer now at client 1).
    set_client(1'b0, 1'b1, 1'b1, 3'd2, 16'h7777);
    @(negedge clk);
    check("midrst_gnt", {31'd0, gnt0}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    check("midrst_access", {31'd0, ram_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async", {23'd0, gnt0, gnt1, done0, done1, ram_en, ram_w, ram_r, ram_add}, 32'd0);
    check("midrst_din_rdata", {ram_din, rdata}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Contention: both held; pointer back at client 0 so order is 0,1,0,1.
    set_client(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000);
    set_client(1'b1, 1'b1, 1'b0, 3'd7, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      wait_gnt(1'b1, 1'b0, got);
      if (got) begin
        check("rr_order", {31'd0, gnt1}, i % 2);
        q.push_back('{gnt1, 1'b1, gnt1 ? 16'h1234 : 16'hFFFF});
        @(posedge clk); #1;
        if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    repeat (2) @(posedge clk);
    #1;

    cmd(1'b1, 1'b1, 3'd4, 16'hC3C3, 16'h0000);
    cmd(1'b0, 1'b0, 3'd4, 16'h0000, 16'hC3C3);

    n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check("drain", q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
